// File: rtl/cmplx_mixer_pkg.sv
// -----------------------------------------------------------------------------
// cmplx_mixer_pkg
//   Shared helpers for the complex mixer: effective scaling shift, internal
//   full-precision widths, pipeline latency and the lane add/subtract select.
// -----------------------------------------------------------------------------
package cmplx_mixer_pkg;

  // Second product is either added to or subtracted from the first.
  typedef enum logic {
    LANE_ADD = 1'b0,
    LANE_SUB = 1'b1
  } lane_op_t;

  // Number of LSBs dropped from the full-precision sum. Zero asks for the
  // natural choice: remove the DDS fraction bits.
  function automatic int eff_shift(input int mul_w, input int dds_w);
    return (mul_w == 0) ? dds_w - 1 : mul_w;
  endfunction

  // Width of one signed product.
  function automatic int prod_width(input int idat_w, input int dds_w);
    return idat_w + dds_w;
  endfunction

  // One guard bit above the product so the two-term sum can never overflow,
  // even for min*min +/- min*min.
  function automatic int sum_width(input int idat_w, input int dds_w);
    return idat_w + dds_w + 1;
  endfunction

  // Input reg, product reg, [extra product reg,] sum reg, output reg.
  function automatic int mixer_latency(input int use_dsp_add);
    return (use_dsp_add != 0) ? 4 : 5;
  endfunction

endpackage

// File: rtl/cmplx_mixer_mac.sv
// -----------------------------------------------------------------------------
// cmplx_mixer_mac
//   One lane of the complex multiplier: dat = scale(a0*b0 +/- a1*b1).
//   Stages: input reg -> product reg -> [extra product reg] -> sum reg ->
//   scaled output reg. Scaling is an arithmetic right shift by pSH with
//   optional round half-up; the final narrowing wraps, or saturates when
//   CMPLX_MIXER_SAT_EN is defined.
//
// Ports:
//   clk     - clock
//   reset   - synchronous active-high reset, clears every register
//   clkena  - clock enable; all registers hold when low
//   a0, b0  - first product operands (data, DDS)
//   a1, b1  - second product operands (data, DDS)
//   dat     - registered scaled result
// -----------------------------------------------------------------------------
module cmplx_mixer_mac
  import cmplx_mixer_pkg::*;
#(
  parameter int       pIDAT_W      = 16,
  parameter int       pDDS_W       = 16,
  parameter int       pODAT_W      = 16,
  parameter int       pSH          = 15,
  parameter int       pUSE_ROUND   = 0,
  parameter int       pUSE_DSP_ADD = 1,
  parameter lane_op_t pOP          = LANE_ADD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clkena,
  input  logic signed [pIDAT_W-1:0]  a0,
  input  logic signed [pDDS_W-1:0]   b0,
  input  logic signed [pIDAT_W-1:0]  a1,
  input  logic signed [pDDS_W-1:0]   b1,
  output logic signed [pODAT_W-1:0]  dat
);

  localparam int PW = prod_width(pIDAT_W, pDDS_W);
  localparam int SW = sum_width(pIDAT_W, pDDS_W);
  // Scaling width: wide enough for the sum and for one bit above the output,
  // so the saturation compare always sees the true sign.
  localparam int XW = (SW > pODAT_W + 1) ? SW : pODAT_W + 1;

  localparam logic signed [XW-1:0] RND =
    (pUSE_ROUND != 0 && pSH > 0) ?
      ({{(XW-1){1'b0}}, 1'b1} << ((pSH > 0) ? pSH - 1 : 0)) : '0;

  localparam logic signed [XW-1:0] OMAX = {{(XW-pODAT_W+1){1'b0}}, {(pODAT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] OMIN = {{(XW-pODAT_W+1){1'b1}}, {(pODAT_W-1){1'b0}}};

  logic signed [pIDAT_W-1:0] a0_r, a1_r;
  logic signed [pDDS_W-1:0]  b0_r, b1_r;
  logic signed [PW-1:0]      p0_r, p1_r;
  logic signed [PW-1:0]      p0_d, p1_d;
  logic signed [SW-1:0]      sum_r;
  logic signed [XW-1:0]      sum_x, rounded, scaled;
  logic signed [pODAT_W-1:0] dat_nxt;

  // NOTE: data registers are reset too (not just the valid chain) so the
  // outputs are deterministic zeros after reset rather than stale samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      a0_r  <= '0;
      b0_r  <= '0;
      a1_r  <= '0;
      b1_r  <= '0;
      p0_r  <= '0;
      p1_r  <= '0;
      sum_r <= '0;
      dat   <= '0;
    end else if (clkena) begin
      a0_r  <= a0;
      b0_r  <= b0;
      a1_r  <= a1;
      b1_r  <= b1;
      // NOTE: both operands are signed, so they are sign-extended to the
      // full product width before multiplying; min*min stays exact.
      p0_r  <= a0_r * b0_r;
      p1_r  <= a1_r * b1_r;
      sum_r <= (pOP == LANE_SUB) ? (p0_d - p1_d) : (p0_d + p1_d);
      dat   <= dat_nxt;
    end
  end

  generate
    if (pUSE_DSP_ADD != 0) begin : g_dsp_add
      // Post-adder sits directly behind the product register.
      assign p0_d = p0_r;
      assign p1_d = p1_r;
    end else begin : g_fabric_add
      // Separate adder: one more register to close timing in fabric.
      logic signed [PW-1:0] p0_q, p1_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          p0_q <= '0;
          p1_q <= '0;
        end else if (clkena) begin
          p0_q <= p0_r;
          p1_q <= p1_r;
        end
      end
      assign p0_d = p0_q;
      assign p1_d = p1_q;
    end
  endgenerate

  // NOTE: every variable gets a value on every path through this block, so
  // no latch is inferred.
  always_comb begin
    sum_x   = XW'(sum_r);
    rounded = sum_x + RND;
    scaled  = rounded >>> pSH;
    dat_nxt = pODAT_W'(scaled);
`ifdef CMPLX_MIXER_SAT_EN
    if (scaled > OMAX) begin
      dat_nxt = pODAT_W'(OMAX);
    end else if (scaled < OMIN) begin
      dat_nxt = pODAT_W'(OMIN);
    end
`endif
  end

endmodule

// File: rtl/cmplx_mixer.sv
// -----------------------------------------------------------------------------
// cmplx_mixer
//   Pipelined complex mixer: out = data * (cos + j*sin), or with pCONJ=1
//   out = data * (cos - j*sin). Result scaled by the effective shift
//   (pMUL_W, or pDDS_W-1 when pMUL_W=0), optionally rounded half-up.
//   Latency 4 enabled cycles (pUSE_DSP_ADD=1) or 5 (pUSE_DSP_ADD=0).
//
// Build option:
//   CMPLX_MIXER_SAT_EN - saturate the final narrowing instead of wrapping.
//
// Ports:
//   iclk     - clock
//   ireset   - synchronous active-high reset (priority over iclkena)
//   iclkena  - clock enable; whole pipeline holds when low
//   ival     - input sample valid
//   idat_re  - input real part        idat_im - input imaginary part
//   icos     - DDS cosine             isin    - DDS sine
//   oval     - output valid (ival delayed by the latency)
//   odat_re  - output real part       odat_im - output imaginary part
// -----------------------------------------------------------------------------
module cmplx_mixer
  import cmplx_mixer_pkg::*;
#(
  parameter int pIDAT_W      = 16,
  parameter int pDDS_W       = 16,
  parameter int pODAT_W      = 16,
  parameter int pMUL_W       = 0,
  parameter int pCONJ        = 0,
  parameter int pUSE_DSP_ADD = 1,
  parameter int pUSE_ROUND   = 0
) (
  input  logic                      iclk,
  input  logic                      ireset,
  input  logic                      iclkena,
  input  logic                      ival,
  input  logic signed [pIDAT_W-1:0] idat_re,
  input  logic signed [pIDAT_W-1:0] idat_im,
  input  logic signed [pDDS_W-1:0]  icos,
  input  logic signed [pDDS_W-1:0]  isin,
  output logic                      oval,
  output logic signed [pODAT_W-1:0] odat_re,
  output logic signed [pODAT_W-1:0] odat_im
);

  localparam int       SH     = eff_shift(pMUL_W, pDDS_W);
  localparam int       LAT    = mixer_latency(pUSE_DSP_ADD);
  localparam lane_op_t RE_OP  = (pCONJ != 0) ? LANE_ADD : LANE_SUB;
  localparam lane_op_t IM_OP  = (pCONJ != 0) ? LANE_SUB : LANE_ADD;

  // Imaginary lane operands:
  //   plain: dr*s + di*c     conjugate: di*c - dr*s
  logic signed [pIDAT_W-1:0] im_a0, im_a1;
  logic signed [pDDS_W-1:0]  im_b0, im_b1;

  assign im_a0 = (pCONJ != 0) ? idat_im : idat_re;
  assign im_b0 = (pCONJ != 0) ? icos    : isin;
  assign im_a1 = (pCONJ != 0) ? idat_re : idat_im;
  assign im_b1 = (pCONJ != 0) ? isin    : icos;

  cmplx_mixer_mac #(
    .pIDAT_W      (pIDAT_W),
    .pDDS_W       (pDDS_W),
    .pODAT_W      (pODAT_W),
    .pSH          (SH),
    .pUSE_ROUND   (pUSE_ROUND),
    .pUSE_DSP_ADD (pUSE_DSP_ADD),
    .pOP          (RE_OP)
  ) u_re (
    .clk    (iclk),
    .reset  (ireset),
    .clkena (iclkena),
    .a0     (idat_re),
    .b0     (icos),
    .a1     (idat_im),
    .b1     (isin),
    .dat    (odat_re)
  );

  cmplx_mixer_mac #(
    .pIDAT_W      (pIDAT_W),
    .pDDS_W       (pDDS_W),
    .pODAT_W      (pODAT_W),
    .pSH          (SH),
    .pUSE_ROUND   (pUSE_ROUND),
    .pUSE_DSP_ADD (pUSE_DSP_ADD),
    .pOP          (IM_OP)
  ) u_im (
    .clk    (iclk),
    .reset  (ireset),
    .clkena (iclkena),
    .a0     (im_a0),
    .b0     (im_b0),
    .a1     (im_a1),
    .b1     (im_b1),
    .dat    (odat_im)
  );

  // Valid travels alongside the data with the same enable and reset.
  logic [LAT-1:0] val_sr;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      val_sr <= '0;
    end else if (iclkena) begin
      val_sr <= {val_sr[LAT-2:0], ival};
    end
  end

  assign oval = val_sr[LAT-1];

endmodule

// File: tb/tb_cmplx_mixer.sv
// -----------------------------------------------------------------------------
// tb_cmplx_mixer
//   Five mixer configurations share one stimulus stream:
//     base  : 17/17/20, truncate, plain phasor, DSP adder (latency 4)
//     rnd   : as base with round half-up
//     conj  : as base with conjugate phasor
//     nodsp : as base with fabric adder (latency 5)
//     narr  : as base with an 8-bit output (wrap, or clamp with SAT_EN)
// -----------------------------------------------------------------------------
module tb_cmplx_mixer;

  logic iclk = 1'b0;
  logic ireset, iclkena, ival;
  logic signed [16:0] idat_re, idat_im, icos, isin;

  logic               b_val, r_val, c_val, n_val, w_val;
  logic signed [19:0] b_re, b_im, r_re, r_im, c_re, c_im, n_re, n_im;
  logic signed [7:0]  w_re, w_im;

  int total = 0;
  int bad   = 0;

  always #5 iclk = ~iclk;

  cmplx_mixer #(.pIDAT_W(17), .pDDS_W(17), .pODAT_W(20), .pMUL_W(0),
                .pCONJ(0), .pUSE_DSP_ADD(1), .pUSE_ROUND(0)) u_base (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
    .idat_re(idat_re), .idat_im(idat_im), .icos(icos), .isin(isin),
    .oval(b_val), .odat_re(b_re), .odat_im(b_im));

  cmplx_mixer #(.pIDAT_W(17), .pDDS_W(17), .pODAT_W(20), .pMUL_W(0),
                .pCONJ(0), .pUSE_DSP_ADD(1), .pUSE_ROUND(1)) u_rnd (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
    .idat_re(idat_re), .idat_im(idat_im), .icos(icos), .isin(isin),
    .oval(r_val), .odat_re(r_re), .odat_im(r_im));

  cmplx_mixer #(.pIDAT_W(17), .pDDS_W(17), .pODAT_W(20), .pMUL_W(0),
                .pCONJ(1), .pUSE_DSP_ADD(1), .pUSE_ROUND(0)) u_conj (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
    .idat_re(idat_re), .idat_im(idat_im), .icos(icos), .isin(isin),
    .oval(c_val), .odat_re(c_re), .odat_im(c_im));

  cmplx_mixer #(.pIDAT_W(17), .pDDS_W(17), .pODAT_W(20), .pMUL_W(0),
                .pCONJ(0), .pUSE_DSP_ADD(0), .pUSE_ROUND(0)) u_nodsp (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
    .idat_re(idat_re), .idat_im(idat_im), .icos(icos), .isin(isin),
    .oval(n_val), .odat_re(n_re), .odat_im(n_im));

  cmplx_mixer #(.pIDAT_W(17), .pDDS_W(17), .pODAT_W(8), .pMUL_W(0),
                .pCONJ(0), .pUSE_DSP_ADD(1), .pUSE_ROUND(0)) u_narr (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
    .idat_re(idat_re), .idat_im(idat_im), .icos(icos), .isin(isin),
    .oval(w_val), .odat_re(w_re), .odat_im(w_im));

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One enabled edge; returns 1 time unit later, away from the edge.
  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic drive(input longint dr, input longint di,
                       input longint c, input longint s);
    idat_re = 17'(dr);
    idat_im = 17'(di);
    icos    = 17'(c);
    isin    = 17'(s);
  endtask

  // Single valid pulse; checks latency and the values of every configuration.
  task automatic run_vec(input string tag,
                         input longint dr, input longint di,
                         input longint c,  input longint s,
                         input longint e_re,  input longint e_im,
                         input longint er_re, input longint er_im,
                         input longint ec_re, input longint ec_im,
                         input longint ew_re, input longint ew_im);
    ival = 1'b1;
    drive(dr, di, c, s);
    step();
    ival = 1'b0;
    drive(0, 0, 0, 0);
    step();
    step();
    check({tag, "_val_at3"}, longint'(b_val), 0);
    step();
    check({tag, "_val_at4"}, longint'(b_val), 1);
    check({tag, "_re"},      longint'(b_re),  e_re);
    check({tag, "_im"},      longint'(b_im),  e_im);
    check({tag, "_rnd_re"},  longint'(r_re),  er_re);
    check({tag, "_rnd_im"},  longint'(r_im),  er_im);
    check({tag, "_conj_re"}, longint'(c_re),  ec_re);
    check({tag, "_conj_im"}, longint'(c_im),  ec_im);
    check({tag, "_narr_re"}, longint'(w_re),  ew_re);
    check({tag, "_narr_im"}, longint'(w_im),  ew_im);
    check({tag, "_nodsp_at4"}, longint'(n_val), 0);
    step();
    check({tag, "_val_at5"},   longint'(b_val), 0);
    check({tag, "_nodsp_at5"}, longint'(n_val), 1);
    check({tag, "_nodsp_re"},  longint'(n_re),  e_re);
    check({tag, "_nodsp_im"},  longint'(n_im),  e_im);
    step();
  endtask

  // Reference arithmetic for the plain phasor with truncation by 16 bits.
  function automatic longint mix_re(longint dr, longint di, longint c, longint s);
    return (dr * c - di * s) >>> 16;
  endfunction

  function automatic longint mix_im(longint dr, longint di, longint c, longint s);
    return (dr * s + di * c) >>> 16;
  endfunction

  localparam longint SAT_HI = 127;
  localparam longint SAT_LO = -128;

  longint exp_re [8];
  longint exp_im [8];

  initial begin
    int ob, on, idx, en_cnt;
    bit stall;

    ireset  = 1'b1;
    iclkena = 1'b1;
    ival    = 1'b1;
    drive(740, 740, 65535, 0);
    step();
    step();
    check("rst_val",    longint'(b_val), 0);
    check("rst_re",     longint'(b_re),  0);
    check("rst_im",     longint'(b_im),  0);
    check("rst_nodsp",  longint'(n_val), 0);
    ireset = 1'b0;
    ival   = 1'b0;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step();

`ifdef CMPLX_MIXER_SAT_EN
    run_vec("v1", 740, 740, 65535, 0,  739, 739, 740, 740,  739, 739,  SAT_HI, SAT_HI);
    run_vec("v2", 740, 740, 0, 65535, -740, 739, -740, 740, 739, -740, SAT_LO, SAT_HI);
    run_vec("vmax", 65535, 0, 65535, 0, 65534, 0, 65534, 0, 65534, 0, SAT_HI, 0);
    run_vec("vmin", -65536, -65536, -65536, -65536,
            0, 131072, 0, 131072, 131072, 0, 0, SAT_HI);
`else
    run_vec("v1", 740, 740, 65535, 0,  739, 739, 740, 740,  739, 739,  -29, -29);
    run_vec("v2", 740, 740, 0, 65535, -740, 739, -740, 740, 739, -740, 28, -29);
    run_vec("vmax", 65535, 0, 65535, 0, 65534, 0, 65534, 0, 65534, 0, -2, 0);
    run_vec("vmin", -65536, -65536, -65536, -65536,
            0, 131072, 0, 131072, 131072, 0, 0, 0);
`endif

    // Streaming with a 3-cycle enable stall in the middle.
    for (int k = 0; k < 8; k++) begin
      exp_re[k] = mix_re(1000*k + 37, 11 - 500*k, 30000 - 1000*k, 2000*k - 7000);
      exp_im[k] = mix_im(1000*k + 37, 11 - 500*k, 30000 - 1000*k, 2000*k - 7000);
    end
    ob = 0;
    on = 0;
    idx = 0;
    en_cnt = 0;
    for (int t = 0; t < 22; t++) begin
      stall   = (t >= 5 && t < 8);
      iclkena = !stall;
      if (!stall) begin
        if (idx < 8) begin
          ival = 1'b1;
          drive(1000*idx + 37, 11 - 500*idx, 30000 - 1000*idx, 2000*idx - 7000);
          idx++;
        end else begin
          ival = 1'b0;
          drive(0, 0, 0, 0);
        end
      end
      step();
      if (stall) begin
        check("stall_val", longint'(b_val), 1);
        if (ob > 0) begin
          check("stall_re", longint'(b_re), exp_re[ob-1]);
          check("stall_im", longint'(b_im), exp_im[ob-1]);
        end
      end else begin
        en_cnt++;
        if (b_val) begin
          if (ob < 8) begin
            check("str_lat",  longint'(en_cnt - 4), longint'(ob));
            check("str_re",   longint'(b_re), exp_re[ob]);
            check("str_im",   longint'(b_im), exp_im[ob]);
          end else begin
            check("str_extra", longint'(ob), 7);
          end
          ob++;
        end
        if (n_val) begin
          if (on < 8) begin
            check("str_nodsp_lat", longint'(en_cnt - 5), longint'(on));
            check("str_nodsp_re",  longint'(n_re), exp_re[on]);
            check("str_nodsp_im",  longint'(n_im), exp_im[on]);
          end else begin
            check("str_nodsp_extra", longint'(on), 7);
          end
          on++;
        end
      end
    end
    check("str_count",       longint'(ob), 8);
    check("str_nodsp_count", longint'(on), 8);

    // Reset with a full pipeline, clock enabled.
    iclkena = 1'b1;
    ival    = 1'b1;
    drive(740, 740, 65535, 0);
    for (int i = 0; i < 4; i++) step();
    ireset = 1'b1;
    step();
    check("flush_val",   longint'(b_val), 0);
    check("flush_re",    longint'(b_re),  0);
    check("flush_im",    longint'(b_im),  0);
    check("flush_nodsp", longint'(n_val), 0);
    check("flush_narr",  longint'(w_re),  0);
    ireset = 1'b0;
    ival   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("flush_quiet", longint'(b_val | n_val), 0);
    end

    // Reset while the clock enable is low.
    ival = 1'b1;
    for (int i = 0; i < 3; i++) step();
    iclkena = 1'b0;
    ireset  = 1'b1;
    step();
    check("dis_rst_re",  longint'(b_re), 0);
    check("dis_rst_im",  longint'(b_im), 0);
    ireset  = 1'b0;
    iclkena = 1'b1;
    ival    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("dis_rst_quiet", longint'(b_val | n_val), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
